switch_scan_ctrl: RTL and testbench

- Avalon-MM master that periodically polls the 8-bit switch PIO (register offset 0).
- Debounces each switch bit independently.
- Emits one event per stable switch transition (bit index, new level) on a valid/ready stream to the MIDI note logic.
- Sits between the switch PIO slave and the note generator, so the CPU no longer needs to busy-poll switches.

---
 rtl/switch_scan_pkg.sv | 39 +++
 rtl/switch_scan_ctrl_if.sv | 23 ++
 rtl/sw_debounce_cell.sv | 34 +++
 rtl/switch_scan_ctrl.sv | 163 ++++++++++++++++
 tb/tb_switch_scan_ctrl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/switch_scan_pkg.sv
// Shared types and helpers for the switch scanner.
package switch_scan_pkg;

  localparam int unsigned SW_WIDTH = 8;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned PIO_DW   = 32;
  localparam int unsigned ADDR_W   = 2;

  localparam logic [ADDR_W-1:0] PIO_DATA_OFFSET = 2'd0;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    EVAL,
    EMIT
  } state_t;

  typedef struct packed {
    logic [IDX_W-1:0] index;
    logic             level;
  } ev_t;

  // Index of the least significant set bit; 0 when nothing is set.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [SW_WIDTH-1:0] v);
    logic [IDX_W-1:0] idx;
    logic             found;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < int'(SW_WIDTH); i++) begin
      if (v[i] && !found) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/switch_scan_ctrl_if.sv
// PIO read port plus the switch-event stream, bundled for the scanner.
interface switch_scan_ctrl_if;
  import switch_scan_pkg::*;

  logic [ADDR_W-1:0] m_address;
  logic              m_read;
  logic [PIO_DW-1:0] m_readdata;
  logic              ev_valid;
  logic              ev_ready;
  logic [IDX_W-1:0]  ev_index;
  logic              ev_level;

  modport master (
    output m_address, m_read, ev_valid, ev_index, ev_level,
    input  m_readdata, ev_ready
  );

  modport slave (
    input  m_address, m_read, ev_valid, ev_index, ev_level,
    output m_readdata, ev_ready
  );

endinterface

// File: rtl/sw_debounce_cell.sv
// Per-bit debounce counter: pulses accept_c when a differing level has been
// seen on DEBOUNCE_CNT consecutive polls.
module sw_debounce_cell #(
  parameter int unsigned DEBOUNCE_CNT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic eval,
  input  logic sample,
  input  logic stable,
  output logic accept_c
);

  localparam int unsigned CNT_W = 4;

  logic [CNT_W-1:0] cnt_q;

  assign accept_c = eval && (sample != stable) &&
                    (cnt_q == CNT_W'(DEBOUNCE_CNT - 1));

  // Count consecutive differing samples; a matching sample restarts the run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (eval) begin
      if ((sample == stable) || accept_c) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/switch_scan_ctrl.sv
// Periodic switch PIO poller with per-bit debounce and a valid/ready event
// stream. Optional interrupt output enabled by defining SWITCH_SCAN_IRQ_EN.
module switch_scan_ctrl
  import switch_scan_pkg::*;
#(
  parameter int unsigned SCAN_PERIOD  = 50000,
  parameter int unsigned DEBOUNCE_CNT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  switch_scan_ctrl_if.master  bus,
  output logic [SW_WIDTH-1:0] stable_state
`ifdef SWITCH_SCAN_IRQ_EN
  ,
  input  logic                irq_mask,
  output logic                irq
`endif
);

  localparam int unsigned TMR_W = $clog2(SCAN_PERIOD);

  state_t              state_q, state_n;
  logic [TMR_W-1:0]    timer_q;
  logic                tick_c;
  logic                tick_latch_q, tick_latch_n;
  logic [SW_WIDTH-1:0] sample_q, sample_n;
  logic [SW_WIDTH-1:0] pending_q, pending_n;
  logic [SW_WIDTH-1:0] stable_q, stable_n;
  logic [SW_WIDTH-1:0] accept_c;
  logic                eval_c;
  logic                m_read_q, m_read_n;
  logic                ev_valid_q, ev_valid_n;
  ev_t                 ev_q, ev_n;
  logic                unused_rd_hi_c;

  assign eval_c         = (state_q == EVAL);
  assign tick_c         = enable && (timer_q == TMR_W'(SCAN_PERIOD - 1));
  assign unused_rd_hi_c = ^bus.m_readdata[PIO_DW-1:SW_WIDTH];

  assign bus.m_address = PIO_DATA_OFFSET;
  assign bus.m_read    = m_read_q;
  assign bus.ev_valid  = ev_valid_q;
  assign bus.ev_index  = ev_q.index;
  assign bus.ev_level  = ev_q.level;
  assign stable_state  = stable_q;

  for (genvar i = 0; i < SW_WIDTH; i++) begin : g_cell
    sw_debounce_cell #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_cell (
      .clk      (clk),
      .reset    (reset),
      .eval     (eval_c),
      .sample   (sample_q[i]),
      .stable   (stable_q[i]),
      .accept_c (accept_c[i])
    );
  end

  // Poll interval timer; parked at zero while scanning is disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
    end else if (!enable || (timer_q == TMR_W'(SCAN_PERIOD - 1))) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + TMR_W'(1);
    end
  end

  // Next-state, datapath updates and next values of the registered outputs.
  always_comb begin
    state_n      = state_q;
    tick_latch_n = tick_latch_q;
    sample_n     = sample_q;
    pending_n    = pending_q;
    stable_n     = stable_q;
    m_read_n     = 1'b0;
    ev_valid_n   = 1'b0;
    ev_n         = '0;

    if (tick_c && (state_q != IDLE)) begin
      tick_latch_n = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (enable && (tick_c || tick_latch_q)) begin
          state_n      = READ;
          tick_latch_n = 1'b0;
        end
      end
      READ: state_n = WAIT;
      WAIT: begin
        sample_n = bus.m_readdata[SW_WIDTH-1:0];
        state_n  = EVAL;
      end
      EVAL: begin
        pending_n = pending_q | accept_c;
        state_n   = (pending_n != '0) ? EMIT : IDLE;
      end
      EMIT: begin
        if (ev_valid_q && bus.ev_ready) begin
          pending_n[ev_q.index] = 1'b0;
          stable_n[ev_q.index]  = ~stable_q[ev_q.index];
        end
        if (pending_n == '0) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (!enable) begin
      tick_latch_n = 1'b0;
    end

    m_read_n = (state_n == READ);
    if (state_n == EMIT) begin
      ev_valid_n  = 1'b1;
      ev_n.index  = lowest_set(pending_n);
      ev_n.level  = ~stable_n[ev_n.index];
    end
  end

  // State and output registers; reset aborts any poll or emit in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      tick_latch_q <= 1'b0;
      sample_q     <= '0;
      pending_q    <= '0;
      stable_q     <= '0;
      m_read_q     <= 1'b0;
      ev_valid_q   <= 1'b0;
      ev_q         <= '0;
    end else begin
      state_q      <= state_n;
      tick_latch_q <= tick_latch_n;
      sample_q     <= sample_n;
      pending_q    <= pending_n;
      stable_q     <= stable_n;
      m_read_q     <= m_read_n;
      ev_valid_q   <= ev_valid_n;
      ev_q         <= ev_n;
    end
  end

`ifdef SWITCH_SCAN_IRQ_EN
  logic irq_q;

  // Interrupt follows "events outstanding", gated by the mask.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_mask && (pending_n != '0);
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_switch_scan_ctrl.sv
// Directed bench for switch_scan_ctrl with SCAN_PERIOD=8, DEBOUNCE_CNT=3.
// Scanning is restarted from a known timer phase before each scenario so
// poll and event cycles can be stated exactly.
module tb_switch_scan_ctrl;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       enable   = 1'b0;
  logic       ev_ready = 1'b1;
  logic [7:0] pio      = 8'h00;
  logic [7:0] model_stable = 8'h00;
  logic [7:0] stable_state;
  int         n_vec = 0;
  int         n_bad = 0;
`ifdef SWITCH_SCAN_IRQ_EN
  logic       irq_mask = 1'b1;
  logic       irq;
`endif

  switch_scan_ctrl_if bus();

  assign bus.ev_ready = ev_ready;

  always #5 clk = ~clk;

  // PIO slave: read data valid the cycle after the strobe, junk otherwise.
  always @(posedge clk) begin
    bus.m_readdata <= bus.m_read ? {24'h5A5A5A, pio} : 32'hA5A5_A5A5;
  end

  switch_scan_ctrl #(.SCAN_PERIOD(8), .DEBOUNCE_CNT(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .bus          (bus),
    .stable_state (stable_state)
`ifdef SWITCH_SCAN_IRQ_EN
    ,
    .irq_mask     (irq_mask),
    .irq          (irq)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance n cycles, counting read strobes and valid cycles seen.
  task automatic run_cnt(input int n, output int rd, output int ev);
    rd = 0;
    ev = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (bus.m_read)   rd++;
      if (bus.ev_valid) ev++;
    end
  endtask

  // Park scanning, then re-enable on this negedge (N0) with a new PIO value.
  // Polls are then visible at N8, N16, N24, ...
  task automatic restart(input logic [7:0] pv);
    enable = 1'b0;
    step(4);
    pio    = pv;
    enable = 1'b1;
  endtask

  // Apply a new switch word and expect the debounced events in index order.
  task automatic debounce_burst(input logic [7:0] pv);
    int         rd, ev;
    logic [7:0] diff;
    restart(pv);
    run_cnt(26, rd, ev);
    chk("polls_before_event", 32'(rd), 3);
    chk("no_early_event", 32'(ev), 0);
    diff = pv ^ model_stable;
    for (int i = 0; i < 8; i++) begin
      if (diff[i]) begin
        @(negedge clk);
        chk("burst_valid", 32'(bus.ev_valid), 1);
        chk("burst_index", 32'(bus.ev_index), 32'(i));
        chk("burst_level", 32'(bus.ev_level), 32'(pv[i]));
      end
    end
    @(negedge clk);
    chk("burst_done_valid", 32'(bus.ev_valid), 0);
    chk("burst_stable", 32'(stable_state), 32'(pv));
    model_stable = pv;
  endtask

  initial begin
    int rd, ev, held;

    // Reset values
    step(2);
    chk("rst_m_read", 32'(bus.m_read), 0);
    chk("rst_m_address", 32'(bus.m_address), 0);
    chk("rst_ev_valid", 32'(bus.ev_valid), 0);
    chk("rst_ev_index", 32'(bus.ev_index), 0);
    chk("rst_ev_level", 32'(bus.ev_level), 0);
    chk("rst_stable", 32'(stable_state), 0);
    reset = 1'b0;

    // No polls while disabled
    run_cnt(20, rd, ev);
    chk("no_poll_disabled", 32'(rd), 0);

    // Idle scanning of an all-zero PIO
    restart(8'h00);
    run_cnt(7, rd, ev);
    chk("first_poll_delay", 32'(rd), 0);
    @(negedge clk);
    chk("poll_strobe", 32'(bus.m_read), 1);
    chk("poll_address", 32'(bus.m_address), 0);
    @(negedge clk);
    chk("read_one_cycle", 32'(bus.m_read), 0);
    run_cnt(31, rd, ev);
    chk("poll_period", 32'(rd), 4);
    chk("idle_no_event", 32'(ev), 0);
    chk("idle_stable", 32'(stable_state), 0);

    // Two simultaneous rising bits
    debounce_burst(8'h05);

    // Bit 3 bounces twice for two polls each: never accepted
    restart(8'h0D);
    run_cnt(17, rd, ev);
    held = ev;
    pio = 8'h05;
    run_cnt(8, rd, ev);
    held += ev;
    pio = 8'h0D;
    run_cnt(16, rd, ev);
    held += ev;
    pio = 8'h05;
    run_cnt(20, rd, ev);
    held += ev;
    chk("bounce_no_event", 32'(held), 0);
    chk("bounce_stable", 32'(stable_state), 32'h05);

    // Falling events
    debounce_burst(8'h00);

    // All bits rise with the sink stalled; extra ticks collapse to one poll
    ev_ready = 1'b0;
    restart(8'hFF);
    run_cnt(26, rd, ev);
    chk("stall_polls", 32'(rd), 3);
    held = 0;
    rd   = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.ev_valid && (bus.ev_index == 3'd0) && bus.ev_level) held++;
      if (bus.m_read) rd++;
    end
    chk("stall_held", 32'(held), 20);
    chk("stall_no_poll", 32'(rd), 0);
    @(negedge clk);
    ev_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      chk("drain_valid", 32'(bus.ev_valid), 1);
      chk("drain_index", 32'(bus.ev_index), 32'(i));
      chk("drain_level", 32'(bus.ev_level), 1);
    end
    @(negedge clk);
    chk("drain_done", 32'(bus.ev_valid), 0);
    chk("drain_stable", 32'(stable_state), 32'hFF);
    @(negedge clk);
    chk("latched_poll", 32'(bus.m_read), 1);
    run_cnt(7, rd, ev);
    chk("single_latched_poll", 32'(rd), 0);
    @(negedge clk);
    chk("next_timer_poll", 32'(bus.m_read), 1);
    model_stable = 8'hFF;

    debounce_burst(8'h00);

    // Reset while emitting with three events pending
    ev_ready = 1'b0;
    restart(8'h2C);
    run_cnt(26, rd, ev);
    chk("pre_rst_polls", 32'(rd), 3);
    @(negedge clk);
    chk("pre_rst_valid", 32'(bus.ev_valid), 1);
    chk("pre_rst_index", 32'(bus.ev_index), 2);
    step(2);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid", 32'(bus.ev_valid), 0);
    chk("async_rst_stable", 32'(stable_state), 0);
    chk("async_rst_index", 32'(bus.ev_index), 0);
    @(negedge clk);
    reset = 1'b0;
    ev_ready = 1'b1;
    model_stable = 8'h00;
    debounce_burst(8'h2C);

`ifdef SWITCH_SCAN_IRQ_EN
    // Interrupt around a single falling event
    debounce_burst(8'hFF);
    ev_ready = 1'b0;
    restart(8'hFE);
    run_cnt(26, rd, ev);
    chk("irq_quiet", 32'(irq), 0);
    @(negedge clk);
    chk("irq_set", 32'(irq), 1);
    chk("irq_ev_index", 32'(bus.ev_index), 0);
    chk("irq_ev_level", 32'(bus.ev_level), 0);
    ev_ready = 1'b1;
    @(negedge clk);
    chk("irq_clear", 32'(irq), 0);
    chk("irq_ev_done", 32'(bus.ev_valid), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
